gpi_irq_ctrl: RTL and testbench

Debounced, interrupt-generating general-purpose input controller for the MMIO slot bus. It synchronises `DATA_WIDTH` external inputs and samples them on a programmable tick. Each bit is debounced, and rising/falling transitions are captured into write-1-to-clear status registers. A single maskable interrupt goes to the processor. It occupies one MMIO slot beside the plain GPI/GPO cores and uses the same slot interface.

---
 rtl/gpi_irq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_gpi_irq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_irq_ctrl.sv
// gpi_irq_ctrl: debounced general-purpose input block with rise/fall status
// capture and a single maskable level interrupt, on the MMIO slot interface.
module gpi_irq_ctrl #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PERIOD_W       = 20,
  parameter int unsigned DEFAULT_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [4:0]            reg_addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  irq
);

  localparam int unsigned BUS_W = 32;

  localparam logic [4:0] ADDR_DATA    = 5'd0;
  localparam logic [4:0] ADDR_RISE    = 5'd1;
  localparam logic [4:0] ADDR_FALL    = 5'd2;
  localparam logic [4:0] ADDR_RISE_EN = 5'd3;
  localparam logic [4:0] ADDR_FALL_EN = 5'd4;
  localparam logic [4:0] ADDR_PERIOD  = 5'd5;

  // State registers and their next-state values
  logic [DATA_WIDTH-1:0] s1_q, s2_q;
  logic [DATA_WIDTH-1:0] samp_q, samp_d;
  logic [DATA_WIDTH-1:0] db_q, db_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d;
  logic [DATA_WIDTH-1:0] fall_q, fall_d;
  logic [DATA_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [DATA_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  irq_q, irq_d;

  // Decoded write strobes and derived control
  logic                  we_rise, we_fall, we_rise_en, we_fall_en, we_period;
  logic                  period_hit, tick;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] accept;
  logic [DATA_WIDTH-1:0] rise_clr, fall_clr;
  logic [DATA_WIDTH-1:0] rise_set, fall_set;

  // Read strobe and the upper write-data bits carry no function here
  logic unused_c;
  assign unused_c = ^{read, wr_data};

  assign wr_bits = wr_data[DATA_WIDTH-1:0];

  // Register write decode: a write happens only on cs & write
  always_comb begin
    we_rise    = 1'b0;
    we_fall    = 1'b0;
    we_rise_en = 1'b0;
    we_fall_en = 1'b0;
    we_period  = 1'b0;
    if (cs && write) begin
      case (reg_addr)
        ADDR_RISE:    we_rise    = 1'b1;
        ADDR_FALL:    we_fall    = 1'b1;
        ADDR_RISE_EN: we_rise_en = 1'b1;
        ADDR_FALL_EN: we_fall_en = 1'b1;
        ADDR_PERIOD:  we_period  = 1'b1;
        default:      ;
      endcase
    end
  end

  // Sample tick: cnt wraps at PERIOD; a PERIOD write restarts it without a tick
  assign period_hit = (cnt_q == period_q);
  assign tick       = period_hit && !we_period;

  // Tick counter and period register next state
  always_comb begin
    cnt_d    = cnt_q + PERIOD_W'(1);
    period_d = period_q;
    if (we_period) begin
      cnt_d    = '0;
      period_d = wr_data[PERIOD_W-1:0];
    end else if (period_hit) begin
      cnt_d = '0;
    end
  end

  // Debounce: a bit is accepted once it reads the same on two consecutive ticks
  always_comb begin
    accept = ~(s2_q ^ samp_q) & (s2_q ^ db_q);
    samp_d = samp_q;
    db_d   = db_q;
    if (tick) begin
      samp_d = s2_q;
      db_d   = (db_q & ~accept) | (s2_q & accept);
    end
  end

  // Edge status: W1C clears, with a coincident new edge taking priority
  always_comb begin
    rise_set = db_d & ~db_q;
    fall_set = ~db_d & db_q;
    rise_clr = we_rise ? wr_bits : '0;
    fall_clr = we_fall ? wr_bits : '0;
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
  end

  // Interrupt enable registers
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (we_rise_en) rise_en_d = wr_bits;
    if (we_fall_en) fall_en_d = wr_bits;
  end

  // Interrupt level from the currently held status and enables
  always_comb begin
    irq_d = (|(rise_q & rise_en_q)) | (|(fall_q & fall_en_q));
  end

  // Two-flop input synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= data_in;
      s2_q <= s1_q;
    end
  end

  // Debounce, status, control and interrupt state
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q    <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      period_q  <= PERIOD_W'(DEFAULT_PERIOD);
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      samp_q    <= samp_d;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  // Combinational read mux, zero-extended to the bus width
  always_comb begin
    rd_data = '0;
    case (reg_addr)
      ADDR_DATA:    rd_data = BUS_W'(db_q);
      ADDR_RISE:    rd_data = BUS_W'(rise_q);
      ADDR_FALL:    rd_data = BUS_W'(fall_q);
      ADDR_RISE_EN: rd_data = BUS_W'(rise_en_q);
      ADDR_FALL_EN: rd_data = BUS_W'(fall_en_q);
      ADDR_PERIOD:  rd_data = BUS_W'(period_q);
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// Bench for gpi_irq_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_gpi_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [15:0] data_in;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  gpi_irq_ctrl #(.DATA_WIDTH(16), .PERIOD_W(20), .DEFAULT_PERIOD(0)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .data_in(data_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_hist[$];          // inputs seen at the last two edges, oldest first
  logic [15:0] m_last_tick_val;    // synchronised value taken at the previous tick
  logic [15:0] m_db, m_rise, m_fall, m_ren, m_fen;
  logic [19:0] m_period;
  int unsigned m_since;            // edges since the last tick or period write
  logic        m_irq;

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back(16'h0);
    m_hist.push_back(16'h0);
    m_last_tick_val = '0;
    m_db = '0; m_rise = '0; m_fall = '0; m_ren = '0; m_fen = '0;
    m_period = 20'd0;
    m_since  = 0;
    m_irq    = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] synced, accepted, wbits;
    bit          wr, tick;
    if (reset) begin
      model_reset();
      return;
    end
    wr     = cs && write;
    wbits  = wr_data[15:0];
    synced = m_hist[0];
    tick   = !(wr && reg_addr == 5'd5) && (m_since == int'(m_period));
    accepted = m_db;
    if (tick)
      for (int b = 0; b < 16; b++)
        if (synced[b] == m_last_tick_val[b]) accepted[b] = synced[b];
    // interrupt reflects status/enables held before this edge
    m_irq = ((m_rise & m_ren) != 0) || ((m_fall & m_fen) != 0);
    if (wr && reg_addr == 5'd1) m_rise = m_rise & ~wbits;
    if (wr && reg_addr == 5'd2) m_fall = m_fall & ~wbits;
    m_rise = m_rise | (accepted & ~m_db);
    m_fall = m_fall | (~accepted & m_db);
    if (wr && reg_addr == 5'd3) m_ren = wbits;
    if (wr && reg_addr == 5'd4) m_fen = wbits;
    if (wr && reg_addr == 5'd5) begin
      m_period = wr_data[19:0];
      m_since  = 0;
    end else if (tick) begin
      m_since = 0;
    end else begin
      m_since++;
    end
    if (tick) m_last_tick_val = synced;
    m_db = accepted;
    void'(m_hist.pop_front());
    m_hist.push_back(data_in);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd0:    return {16'h0, m_db};
      5'd1:    return {16'h0, m_rise};
      5'd2:    return {16'h0, m_fall};
      5'd3:    return {16'h0, m_ren};
      5'd4:    return {16'h0, m_fen};
      5'd5:    return {12'h0, m_period};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) model_edge();

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq_vs_model", {31'h0, irq}, {31'h0, m_irq});
      check("rd_data_vs_model", rd_data, model_read(reg_addr));
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    cyc(1);
    cs = 1'b0; write = 1'b0; wr_data = $urandom;
  endtask

  task automatic expect_reg(input string nm, input logic [4:0] a, input logic [31:0] e);
    reg_addr = a;
    #1;
    check(nm, rd_data, e);
  endtask

  initial begin
    model_reset();
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    reg_addr = 5'd0; wr_data = 32'h0; data_in = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // 1: reset contents
    expect_reg("t1_data", 5'd0, 32'h0);
    expect_reg("t1_rise", 5'd1, 32'h0);
    expect_reg("t1_fall", 5'd2, 32'h0);
    expect_reg("t1_rise_en", 5'd3, 32'h0);
    expect_reg("t1_fall_en", 5'd4, 32'h0);
    expect_reg("t1_period", 5'd5, 32'h0);
    expect_reg("t1_addr31", 5'd31, 32'h0);
    check("t1_irq", {31'h0, irq}, 32'h0);

    // 2: PERIOD=0 latency, then W1C
    wr(5'd5, 32'h0);
    wr(5'd3, 32'h1);
    data_in = 16'h0001;
    cyc(3);
    expect_reg("t2_data_e3", 5'd0, 32'h0);
    cyc(1);
    expect_reg("t2_data_e4", 5'd0, 32'h1);
    expect_reg("t2_rise_e4", 5'd1, 32'h1);
    check("t2_irq_e4", {31'h0, irq}, 32'h0);
    cyc(1);
    check("t2_irq_e5", {31'h0, irq}, 32'h1);
    wr(5'd1, 32'h1);
    expect_reg("t2_rise_clr", 5'd1, 32'h0);
    check("t2_irq_wr_edge", {31'h0, irq}, 32'h1);
    cyc(1);
    check("t2_irq_cleared", {31'h0, irq}, 32'h0);

    // cleanup
    data_in = 16'h0;
    cyc(6);
    wr(5'd1, 32'hFFFF);
    wr(5'd2, 32'hFFFF);
    wr(5'd3, 32'h0);

    // 3: PERIOD=9 glitch rejection and slow debounce
    wr(5'd5, 32'd9);
    data_in = 16'h0008;
    cyc(5);
    data_in = 16'h0;
    cyc(30);
    expect_reg("t3_glitch_data", 5'd0, 32'h0);
    expect_reg("t3_glitch_rise", 5'd1, 32'h0);
    expect_reg("t3_glitch_fall", 5'd2, 32'h0);
    data_in = 16'h0008;
    cyc(22);
    expect_reg("t3_high_data", 5'd0, 32'h8);
    expect_reg("t3_high_rise", 5'd1, 32'h8);
    cyc(18);
    data_in = 16'h0;
    cyc(22);
    expect_reg("t3_low_fall", 5'd2, 32'h8);
    expect_reg("t3_low_data", 5'd0, 32'h0);

    // 4: W1C coinciding with a new rising edge
    wr(5'd5, 32'h0);
    wr(5'd1, 32'hFFFF);
    wr(5'd2, 32'hFFFF);
    wr(5'd3, 32'h4);
    data_in = 16'h0004;
    cyc(6);
    data_in = 16'h0;
    cyc(6);
    check("t4_irq_pending", {31'h0, irq}, 32'h1);
    data_in = 16'h0004;
    cyc(3);
    wr(5'd1, 32'h4);
    expect_reg("t4_rise_kept", 5'd1, 32'h4);
    check("t4_irq_kept", {31'h0, irq}, 32'h1);
    cyc(1);
    check("t4_irq_kept2", {31'h0, irq}, 32'h1);

    // 5: masking of a pending fall
    data_in = 16'h0;
    cyc(6);
    wr(5'd3, 32'h0);
    wr(5'd4, 32'h0);
    wr(5'd1, 32'hFFFF);
    wr(5'd2, 32'hFFFF);
    data_in = 16'h0010;
    cyc(6);
    data_in = 16'h0;
    cyc(6);
    expect_reg("t5_fall", 5'd2, 32'h10);
    check("t5_irq_masked", {31'h0, irq}, 32'h0);
    wr(5'd4, 32'h10);
    check("t5_irq_wr_edge", {31'h0, irq}, 32'h0);
    cyc(1);
    check("t5_irq_enabled", {31'h0, irq}, 32'h1);

    // 6: reset mid-debounce
    wr(5'd5, 32'h0);
    data_in = 16'hFFFF;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    expect_reg("t6_rst_data", 5'd0, 32'h0);
    expect_reg("t6_rst_rise", 5'd1, 32'h0);
    expect_reg("t6_rst_fall_en", 5'd4, 32'h0);
    check("t6_rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    cyc(3);
    expect_reg("t6_data_e3", 5'd0, 32'h0);
    cyc(1);
    expect_reg("t6_data", 5'd0, 32'hFFFF);
    expect_reg("t6_rise", 5'd1, 32'hFFFF);

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) data_in = data_in ^ 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 60) == 0) data_in = 16'($urandom);
      reg_addr = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      cs       = ($urandom_range(0, 7) == 0);
      write    = ($urandom_range(0, 1) == 1);
      read     = ($urandom_range(0, 1) == 1);
      wr_data  = $urandom;
      if (reg_addr == 5'd5) wr_data = {$urandom_range(0, 1) == 0 ? 12'h0 : 12'hFFF,
                                       20'($urandom_range(0, 3))};
      reset    = ($urandom_range(0, 599) == 0);
      cyc(1);
    end

    reset = 1'b0; cs = 1'b0; write = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
